serv_gpio_bank: RTL and testbench

SERV_GPIO_BANK -- requirements
Module: serv_gpio_bank

---
 rtl/serv_gpio_bank.sv | 108 ++++++++++
 tb/tb_serv_gpio_bank.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_gpio_bank.sv
// Wishbone-attached GPIO bank: output/enable registers, synchronised inputs,
// per-pin edge detection into write-1-to-clear pending bits and a level IRQ.
module serv_gpio_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_wb_clk,
    input  logic             i_wb_rst,
    input  logic [2:0]       i_wb_adr,
    input  logic [31:0]      i_wb_dat,
    input  logic             i_wb_we,
    input  logic             i_wb_stb,
    output logic [31:0]      o_wb_rdt,
    output logic             o_wb_ack,
    input  logic [WIDTH-1:0] i_gpio,
    output logic [WIDTH-1:0] o_gpio,
    output logic [WIDTH-1:0] o_gpio_oe,
    output logic             o_irq
);

    localparam logic [2:0] ADR_OUT  = 3'd0;
    localparam logic [2:0] ADR_OE   = 3'd1;
    localparam logic [2:0] ADR_IN   = 3'd2;
    localparam logic [2:0] ADR_IE   = 3'd3;
    localparam logic [2:0] ADR_EDGE = 3'd4;
    localparam logic [2:0] ADR_PEND = 3'd5;

    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] oe_r;
    logic [WIDTH-1:0] ie_r;
    logic [WIDTH-1:0] edge_r;
    logic [WIDTH-1:0] pend_r;
    logic [WIDTH-1:0] prev_p;
    logic [WIDTH-1:0] sync_p [SYNC_STAGES];

    logic [WIDTH-1:0] in_w;
    logic [WIDTH-1:0] wdat;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] rd_sel;
    logic             access;
    logic             wr;
    logic             unused_dat;

    // A request is taken only when no ack is outstanding, so a held strobe
    // is serviced every other cycle.
    assign access = i_wb_stb & ~o_wb_ack;
    assign wr     = access & i_wb_we;
    assign wdat   = i_wb_dat[WIDTH-1:0];
    assign unused_dat = ^(i_wb_dat >> WIDTH);

    assign in_w = sync_p[SYNC_STAGES-1];
    assign evt  = (edge_r & ~in_w & prev_p) | (~edge_r & in_w & ~prev_p);
    assign clr  = (wr && (i_wb_adr == ADR_PEND)) ? wdat : '0;

    assign o_gpio    = out_r;
    assign o_gpio_oe = oe_r;
    assign o_irq     = |(pend_r & ie_r);

    always_comb begin
        rd_sel = '0;
        case (i_wb_adr)
            ADR_OUT:  rd_sel = out_r;
            ADR_OE:   rd_sel = oe_r;
            ADR_IN:   rd_sel = in_w;
            ADR_IE:   rd_sel = ie_r;
            ADR_EDGE: rd_sel = edge_r;
            ADR_PEND: rd_sel = pend_r;
            default:  rd_sel = '0;
        endcase
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            out_r    <= '0;
            oe_r     <= '0;
            ie_r     <= '0;
            edge_r   <= '0;
            pend_r   <= '0;
            prev_p   <= '0;
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
        end else begin
            o_wb_ack <= access;
            o_wb_rdt <= access ? 32'(rd_sel) : 32'd0;

            // input synchroniser chain -> IN, then one more stage for edge history
            sync_p[0] <= i_gpio;
            for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
            prev_p <= in_w;

            // new events override a same-edge clear
            pend_r <= (pend_r & ~clr) | evt;

            if (wr) begin
                case (i_wb_adr)
                    ADR_OUT:  out_r  <= wdat;
                    ADR_OE:   oe_r   <= wdat;
                    ADR_IE:   ie_r   <= wdat;
                    ADR_EDGE: edge_r <= wdat;
                    default:  ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serv_gpio_bank.sv
// Self-checking bench for serv_gpio_bank (WIDTH=8, SYNC_STAGES=2): register
// vector table plus hand-written sequences for edge, pending and reset timing.
module tb_serv_gpio_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  adr;
    logic [31:0] dat;
    logic        we;
    logic        stb;
    logic [31:0] rdt;
    logic        ack;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  adr;
        logic        we;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb_q[$];

    serv_gpio_bank #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .i_wb_clk (clk),
        .i_wb_rst (rst),
        .i_wb_adr (adr),
        .i_wb_dat (dat),
        .i_wb_we  (we),
        .i_wb_stb (stb),
        .o_wb_rdt (rdt),
        .o_wb_ack (ack),
        .i_gpio   (gpio_in),
        .o_gpio   (gpio_out),
        .o_gpio_oe(gpio_oe),
        .o_irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Pop the oldest expected read value and compare against the bus.
    task automatic sb_pop(input string name);
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s: got unexpected ack rdt=0x%08h expected no ack", name, rdt);
        end else begin
            logic [31:0] e;
            e = sb_q.pop_front();
            if (rdt !== e) begin
                failures++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", name, rdt, e);
            end
        end
    endtask

    task automatic bus(input logic [2:0] a, input logic w, input logic [31:0] d,
                       input logic [31:0] exp, input string name);
        bit got;
        if (!w) sb_q.push_back(exp);
        @(negedge clk);
        adr = a; we = w; dat = d; stb = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) got = 1'b1;
        end
        stb = 1'b0;
        if (!got) begin
            checks++; failures++;
            $display("FAIL %s: got no ack expected ack within 4 cycles", name);
            if (!w) void'(sb_q.pop_back());
        end else if (!w) begin
            sb_pop(name);
        end else begin
            chk(name, 32'(ack), 32'd1);
        end
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [2:0] a, input logic w,
                                input logic [31:0] d, input logic [31:0] e);
        vec_t v;
        v.adr = a; v.we = w; v.dat = d; v.exp = e;
        return v;
    endfunction

    initial begin
        int ack_cnt;
        rst = 1'b1; adr = '0; dat = '0; we = 1'b0; stb = 1'b0; gpio_in = 8'h00;

        // Reset with a write strobe present: it must be discarded.
        @(negedge clk);
        stb = 1'b1; we = 1'b1; adr = 3'd0; dat = 32'hFF;
        wait_cyc(3);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rdt", rdt, 32'd0);
        chk("rst_gpio", 32'(gpio_out), 32'd0);
        chk("rst_oe", 32'(gpio_oe), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("idle_rdt", rdt, 32'd0);

        for (int a = 0; a < 8; a++) vecs.push_back(mk(3'(a), 1'b0, 32'h0, 32'h0));
        vecs.push_back(mk(3'd0, 1'b1, 32'hFFFFFFA5, 32'h0));
        vecs.push_back(mk(3'd1, 1'b1, 32'h0000000F, 32'h0));
        vecs.push_back(mk(3'd0, 1'b0, 32'h0, 32'h000000A5));
        vecs.push_back(mk(3'd1, 1'b0, 32'h0, 32'h0000000F));
        vecs.push_back(mk(3'd2, 1'b1, 32'hFF, 32'h0));
        vecs.push_back(mk(3'd2, 1'b0, 32'h0, 32'h0));
        vecs.push_back(mk(3'd6, 1'b1, 32'hFFFFFFFF, 32'h0));
        vecs.push_back(mk(3'd6, 1'b0, 32'h0, 32'h0));
        vecs.push_back(mk(3'd7, 1'b1, 32'hFFFFFFFF, 32'h0));
        vecs.push_back(mk(3'd7, 1'b0, 32'h0, 32'h0));
        vecs.push_back(mk(3'd3, 1'b1, 32'h000001FF, 32'h0));
        vecs.push_back(mk(3'd3, 1'b0, 32'h0, 32'h000000FF));
        vecs.push_back(mk(3'd4, 1'b1, 32'h0000005A, 32'h0));
        vecs.push_back(mk(3'd4, 1'b0, 32'h0, 32'h0000005A));
        vecs.push_back(mk(3'd3, 1'b1, 32'h0, 32'h0));
        vecs.push_back(mk(3'd4, 1'b1, 32'h0, 32'h0));
        vecs.push_back(mk(3'd5, 1'b0, 32'h0, 32'h0));

        foreach (vecs[i]) bus(vecs[i].adr, vecs[i].we, vecs[i].dat, vecs[i].exp,
                              $sformatf("vec%0d_adr%0d", i, vecs[i].adr));
        chk("gpio_out", 32'(gpio_out), 32'hA5);
        chk("gpio_oe", 32'(gpio_oe), 32'h0F);

        // Rising edge on pin 2: IN after two edges, PEND one edge later.
        bus(3'd3, 1'b1, 32'h04, 32'h0, "ie_wr");
        @(posedge clk); #1;
        gpio_in = 8'h04;
        wait_cyc(2);
        chk("irq_before_pend", 32'(irq), 32'd0);
        wait_cyc(1);
        chk("irq_after_pend", 32'(irq), 32'd1);
        bus(3'd2, 1'b0, 32'h0, 32'h04, "in_rd");
        bus(3'd5, 1'b0, 32'h0, 32'h04, "pend_rise");

        // Falling-edge selection and write-1-to-clear.
        bus(3'd5, 1'b1, 32'h04, 32'h0, "pend_clr");
        bus(3'd5, 1'b0, 32'h0, 32'h0, "pend_cleared");
        chk("irq_cleared", 32'(irq), 32'd0);
        bus(3'd4, 1'b1, 32'h04, 32'h0, "edge_fall");
        wait_cyc(4);
        bus(3'd5, 1'b0, 32'h0, 32'h0, "pend_no_edge_change");
        gpio_in = 8'h00;
        wait_cyc(4);
        chk("irq_fall", 32'(irq), 32'd1);
        bus(3'd5, 1'b0, 32'h0, 32'h04, "pend_fall");
        bus(3'd5, 1'b1, 32'h00, 32'h0, "pend_wr0");
        bus(3'd5, 1'b0, 32'h0, 32'h04, "pend_kept");
        bus(3'd5, 1'b1, 32'h04, 32'h0, "pend_clr2");
        bus(3'd5, 1'b0, 32'h0, 32'h0, "pend_clr2_rd");
        chk("irq_clr2", 32'(irq), 32'd0);

        // Clear colliding with a fresh rising event: set wins.
        bus(3'd4, 1'b1, 32'h00, 32'h0, "edge_rise");
        gpio_in = 8'h04;
        wait_cyc(5);
        bus(3'd5, 1'b0, 32'h0, 32'h04, "pend_pre_coll");
        gpio_in = 8'h00;
        wait_cyc(5);
        @(posedge clk); #1;
        gpio_in = 8'h04;
        wait_cyc(2);
        @(negedge clk);
        adr = 3'd5; we = 1'b1; dat = 32'h04; stb = 1'b1;
        @(posedge clk); #1;
        chk("coll_ack", 32'(ack), 32'd1);
        stb = 1'b0;
        bus(3'd5, 1'b0, 32'h0, 32'h04, "pend_coll");

        // Held strobe for six edges: three ack pulses.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) sb_q.push_back(32'h000000A5);
        ack_cnt = 0;
        @(negedge clk);
        adr = 3'd0; we = 1'b0; stb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                ack_cnt++;
                sb_pop($sformatf("held_rd%0d", i));
            end
        end
        chk("held_acks", 32'(ack_cnt), 32'd3);
        chk("held_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset during a write strobe, then first ack right after release.
        @(negedge clk);
        we = 1'b1; dat = 32'h3C; rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_gpio", 32'(gpio_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ack", 32'(ack), 32'd1);
        chk("post_rst_gpio", 32'(gpio_out), 32'h3C);
        stb = 1'b0; we = 1'b0;

        // Pins high through reset: one rising event after release, then quiet.
        gpio_in = 8'h81;
        @(negedge clk);
        rst = 1'b1;
        wait_cyc(3);
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(8);
        bus(3'd5, 1'b0, 32'h0, 32'h81, "pend_after_rst");
        bus(3'd5, 1'b1, 32'hFF, 32'h0, "pend_clr_all");
        wait_cyc(8);
        bus(3'd5, 1'b0, 32'h0, 32'h0, "pend_once");
        chk("irq_ie_reset", 32'(irq), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
